// File: rtl/spike_sched_mc_pkg.sv
// Shared constants for the multi-channel spike scheduler.
// Event word layout {virt, addr} and arbitration mode encodings.
package spike_sched_mc_pkg;

   localparam int VIRT_W = 2;
   localparam int M      = 10;
   localparam int DW     = VIRT_W + M;

   typedef enum logic {
      ARB_FIXED = 1'b0,
      ARB_RR    = 1'b1
   } arb_mode_e;

endpackage

// File: rtl/spike_sched_mc_sched_fifo.sv
// First-word-fall-through FIFO for one scheduler channel.
// Ports: clk/rst, push/din, pop, head (current oldest word), empty, full.
module sched_fifo #(
   parameter int WIDTH    = 12,
   parameter int DEPTH    = 128,
   parameter int DEPTH_AW = 7
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             push,
   input  logic [WIDTH-1:0] din,
   input  logic             pop,
   output logic [WIDTH-1:0] head,
   output logic             empty,
   output logic             full
);

   logic [WIDTH-1:0]  mem_q [DEPTH];
   logic [DEPTH_AW-1:0] wr_ptr_q, wr_ptr_d;
   logic [DEPTH_AW-1:0] rd_ptr_q, rd_ptr_d;
   logic [DEPTH_AW:0]   cnt_q, cnt_d;
   logic                do_push, do_pop;

   assign empty   = (cnt_q == '0);
   assign full    = (cnt_q == (DEPTH_AW+1)'(DEPTH));
   assign do_push = push & ~full;
   assign do_pop  = pop & ~empty;
   assign head    = mem_q[rd_ptr_q];

   // Pointers are DEPTH_AW wide, so wrap modulo DEPTH falls out naturally.
   always_comb begin
      wr_ptr_d = wr_ptr_q + DEPTH_AW'(do_push);
      rd_ptr_d = rd_ptr_q + DEPTH_AW'(do_pop);
      cnt_d    = cnt_q + (DEPTH_AW+1)'(do_push)
                       - (DEPTH_AW+1)'(do_pop);
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         cnt_q    <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         cnt_q    <= cnt_d;
      end
   end

   // Storage needs no reset; only the pointers define validity.
   always_ff @(posedge clk) begin
      if (do_push) mem_q[wr_ptr_q] <= din;
   end

endmodule

// File: rtl/spike_sched_mc.sv
// Multi-channel spike event scheduler: per-channel FIFOs, fixed/RR arbiter,
// output register with valid/ready, open-loop suppression of channel 0,
// saturating drop counter. SPI_* config inputs are 2-flop synchronised.
module spike_sched_mc
   import spike_sched_mc_pkg::*;
#(
   parameter int NCH      = 2,
   parameter int DEPTH    = 128,
   parameter int DEPTH_AW = 7,
   parameter int DROP_W   = 16,
   parameter int CHW      = (NCH > 1) ? $clog2(NCH) : 1
) (
   input  logic              CLK,
   input  logic              RST,
   input  logic [NCH-1:0]    PUSH_VALID,
   input  logic [NCH*DW-1:0] PUSH_DATA,
   output logic [NCH-1:0]    PUSH_FULL,
   input  logic              SPI_OPEN_LOOP,
   input  logic              SPI_ARB_RR,
   input  logic              SPI_DROP_CLR,
   output logic              SCHED_VALID,
   input  logic              SCHED_READY,
   output logic [DW-1:0]     SCHED_DATA_OUT,
   output logic [CHW-1:0]    SCHED_CH,
   output logic              SCHED_EMPTY,
   output logic [DROP_W-1:0] SCHED_DROP_CNT
);

   logic [2:0]        spi_s1_q, spi_s1_d;
   logic [2:0]        spi_s2_q, spi_s2_d;
   logic              open_loop, drop_clr;
   arb_mode_e         arb_mode;

   logic [NCH-1:0]    push_req, push_en, drop, pop;
   logic [NCH-1:0]    empty, full;
   logic [DW-1:0]     head [NCH];

   logic              valid_q, valid_d;
   logic [DW-1:0]     data_q, data_d;
   logic [CHW-1:0]    ch_q, ch_d;
   logic [CHW-1:0]    rr_q, rr_d;
   logic [DROP_W-1:0] drop_q, drop_d;

   logic              any_ne, found, load;
   logic [CHW-1:0]    grant;
   logic [DROP_W:0]   drop_sum;
   int                idx;

   assign spi_s1_d  = {SPI_DROP_CLR, SPI_ARB_RR, SPI_OPEN_LOOP};
   assign spi_s2_d  = spi_s1_q;
   assign open_loop = spi_s2_q[0];
   assign arb_mode  = arb_mode_e'(spi_s2_q[1]);
   assign drop_clr  = spi_s2_q[2];

   // Full comes from registered state: a pop this cycle frees nothing.
   for (genvar i = 0; i < NCH; i++) begin : g_ch
      assign push_req[i] = PUSH_VALID[i] & ~((i == 0) & open_loop);
      assign push_en[i]  = push_req[i] & ~full[i];
      assign drop[i]     = push_req[i] & full[i];

      sched_fifo #(
         .WIDTH    (DW),
         .DEPTH    (DEPTH),
         .DEPTH_AW (DEPTH_AW)
      ) u_fifo (
         .clk   (CLK),
         .rst   (RST),
         .push  (push_en[i]),
         .din   (PUSH_DATA[i*DW +: DW]),
         .pop   (pop[i]),
         .head  (head[i]),
         .empty (empty[i]),
         .full  (full[i])
      );
   end

   assign any_ne = ~&empty;
   assign load   = ~valid_q | SCHED_READY;

   // Grant search: fixed scans from 0; RR scans from rr_q+1 modulo NCH.
   always_comb begin
      grant = '0;
      found = 1'b0;
      idx   = 0;
      for (int k = 0; k < NCH; k++) begin
         if (arb_mode == ARB_RR) idx = (int'(rr_q) + 1 + k) % NCH;
         else                    idx = k;
         if (!found && !empty[idx]) begin
            grant = CHW'(idx);
            found = 1'b1;
         end
      end
   end

   always_comb begin
      valid_d = valid_q;
      data_d  = data_q;
      ch_d    = ch_q;
      rr_d    = rr_q;
      pop     = '0;
      if (load) begin
         if (any_ne) begin
            valid_d     = 1'b1;
            data_d      = head[grant];
            ch_d        = grant;
            rr_d        = grant;
            pop[grant]  = 1'b1;
         end else begin
            valid_d = 1'b0;
         end
      end
   end

   always_comb begin
      drop_sum = {1'b0, drop_q};
      for (int i = 0; i < NCH; i++)
         drop_sum = drop_sum + (DROP_W+1)'(drop[i]);
      if (drop_clr)           drop_d = '0;
      else if (drop_sum[DROP_W]) drop_d = '1;
      else                    drop_d = drop_sum[DROP_W-1:0];
   end

   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         spi_s1_q <= '0;
         spi_s2_q <= '0;
         valid_q  <= 1'b0;
         data_q   <= '0;
         ch_q     <= '0;
         rr_q     <= CHW'(NCH - 1);
         drop_q   <= '0;
      end else begin
         spi_s1_q <= spi_s1_d;
         spi_s2_q <= spi_s2_d;
         valid_q  <= valid_d;
         data_q   <= data_d;
         ch_q     <= ch_d;
         rr_q     <= rr_d;
         drop_q   <= drop_d;
      end
   end

   assign PUSH_FULL      = full;
   assign SCHED_VALID    = valid_q;
   assign SCHED_DATA_OUT = data_q;
   assign SCHED_CH       = ch_q;
   assign SCHED_DROP_CNT = drop_q;
   assign SCHED_EMPTY    = ~any_ne & ~valid_q;

endmodule

// File: tb/tb_spike_sched_mc.sv
// Randomised bench for spike_sched_mc against a queue-based event model.
// Directed phases pin the model with literal expectations.
module tb_spike_sched_mc;

   localparam int NCH   = 2;
   localparam int DW    = 12;
   localparam int CHW   = 1;
   localparam int DEPTH = 128;
   localparam int DMAX  = 65535;

   logic              CLK = 1'b0;
   logic              RST;
   logic [NCH-1:0]    PUSH_VALID;
   logic [NCH*DW-1:0] PUSH_DATA;
   logic [NCH-1:0]    PUSH_FULL;
   logic              SPI_OPEN_LOOP, SPI_ARB_RR, SPI_DROP_CLR;
   logic              SCHED_VALID, SCHED_READY, SCHED_EMPTY;
   logic [DW-1:0]     SCHED_DATA_OUT;
   logic [CHW-1:0]    SCHED_CH;
   logic [15:0]       SCHED_DROP_CNT;

   always #5 CLK = ~CLK;

   spike_sched_mc dut (
      .CLK            (CLK),
      .RST            (RST),
      .PUSH_VALID     (PUSH_VALID),
      .PUSH_DATA      (PUSH_DATA),
      .PUSH_FULL      (PUSH_FULL),
      .SPI_OPEN_LOOP  (SPI_OPEN_LOOP),
      .SPI_ARB_RR     (SPI_ARB_RR),
      .SPI_DROP_CLR   (SPI_DROP_CLR),
      .SCHED_VALID    (SCHED_VALID),
      .SCHED_READY    (SCHED_READY),
      .SCHED_DATA_OUT (SCHED_DATA_OUT),
      .SCHED_CH       (SCHED_CH),
      .SCHED_EMPTY    (SCHED_EMPTY),
      .SCHED_DROP_CNT (SCHED_DROP_CNT)
   );

   int vec = 0;
   int mis = 0;

   // Behavioural model: one queue per channel plus the presented event.
   logic [DW-1:0] mq [NCH][$];
   bit            mv;
   logic [DW-1:0] md;
   int            mc, mrr, mdrop;
   bit            ol1, ol2, rr1, rr2, cl1, cl2;
   int            got [$];

   task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
      vec++;
      if (act !== exp) begin
         mis++;
         $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
      end
   endtask

   task automatic model_reset();
      for (int i = 0; i < NCH; i++) mq[i].delete();
      mv = 0; md = '0; mc = 0; mrr = NCH - 1; mdrop = 0;
      ol1 = 0; ol2 = 0; rr1 = 0; rr2 = 0; cl1 = 0; cl2 = 0;
   endtask

   function automatic bit m_empty();
      for (int i = 0; i < NCH; i++) if (mq[i].size() != 0) return 0;
      return !mv;
   endfunction

   task automatic model_edge();
      bit full [NCH];
      int g, drops;
      bit found;
      for (int i = 0; i < NCH; i++) full[i] = (mq[i].size() == DEPTH);
      if (!mv || SCHED_READY) begin
         found = 0; g = 0;
         for (int k = 0; k < NCH; k++) begin
            int c;
            c = rr2 ? (mrr + 1 + k) % NCH : k;
            if (!found && mq[c].size() != 0) begin
               g = c; found = 1;
            end
         end
         if (found) begin
            md = mq[g].pop_front(); mc = g; mv = 1; mrr = g;
         end else begin
            mv = 0;
         end
      end
      drops = 0;
      for (int i = 0; i < NCH; i++) begin
         if (PUSH_VALID[i] && !(i == 0 && ol2)) begin
            if (full[i]) drops++;
            else mq[i].push_back(PUSH_DATA[i*DW +: DW]);
         end
      end
      if (cl2) mdrop = 0;
      else mdrop = (mdrop + drops > DMAX) ? DMAX : mdrop + drops;
      ol2 = ol1; ol1 = SPI_OPEN_LOOP;
      rr2 = rr1; rr1 = SPI_ARB_RR;
      cl2 = cl1; cl1 = SPI_DROP_CLR;
   endtask

   task automatic check_all();
      logic [NCH-1:0] f;
      for (int i = 0; i < NCH; i++) f[i] = (mq[i].size() == DEPTH);
      chk("valid", 32'(SCHED_VALID), 32'(mv));
      if (mv) begin
         chk("data", 32'(SCHED_DATA_OUT), 32'(md));
         chk("ch", 32'(SCHED_CH), 32'(mc));
      end
      chk("full", 32'(PUSH_FULL), 32'(f));
      chk("empty", 32'(SCHED_EMPTY), 32'(m_empty()));
      chk("drop", 32'(SCHED_DROP_CNT), 32'(mdrop));
   endtask

   task automatic step();
      if (SCHED_VALID === 1'b1 && SCHED_READY) got.push_back(int'(SCHED_CH));
      @(posedge CLK);
      model_edge();
      #1;
      check_all();
   endtask

   task automatic do_reset();
      RST = 1'b1;
      #1;
      chk("rst_valid", 32'(SCHED_VALID), 32'd0);
      chk("rst_empty", 32'(SCHED_EMPTY), 32'd1);
      chk("rst_data", 32'(SCHED_DATA_OUT), 32'd0);
      chk("rst_drop", 32'(SCHED_DROP_CNT), 32'd0);
      chk("rst_full", 32'(PUSH_FULL), 32'd0);
      model_reset();
      @(posedge CLK);
      #1;
      RST = 1'b0;
      check_all();
   endtask

   task automatic preload3();
      SCHED_READY = 1'b0;
      for (int i = 0; i < 3; i++) begin
         PUSH_VALID = 2'b11;
         PUSH_DATA  = {12'(12'h100 + i), 12'(12'h200 + i)};
         step();
      end
      PUSH_VALID = '0;
      got.delete();
      SCHED_READY = 1'b1;
      for (int i = 0; i < 8; i++) step();
   endtask

   task automatic chk_order(string nm, int exp [6]);
      chk({nm, "_n"}, 32'(got.size()), 32'd6);
      for (int i = 0; i < 6 && i < got.size(); i++)
         chk(nm, 32'(got[i]), 32'(exp[i]));
   endtask

   initial begin
      PUSH_VALID = '0; PUSH_DATA = '0; SCHED_READY = 1'b0;
      SPI_OPEN_LOOP = 0; SPI_ARB_RR = 0; SPI_DROP_CLR = 0;
      RST = 1'b1;
      model_reset();
      #2;
      do_reset();

      // Single event on ch1
      SCHED_READY = 1'b1;
      PUSH_VALID  = 2'b10;
      PUSH_DATA   = {2'b01, 10'd37, 12'h000};
      step();
      chk("single_empty0", 32'(SCHED_EMPTY), 32'd0);
      PUSH_VALID = '0;
      step();
      chk("single_valid", 32'(SCHED_VALID), 32'd1);
      chk("single_data", 32'(SCHED_DATA_OUT), 32'h425);
      chk("single_ch", 32'(SCHED_CH), 32'd1);
      step();
      chk("single_empty1", 32'(SCHED_EMPTY), 32'd1);

      // Fixed priority then round-robin ordering
      preload3();
      chk_order("fixed_order", '{0, 0, 0, 1, 1, 1});
      SPI_ARB_RR = 1'b1;
      for (int i = 0; i < 3; i++) step();
      preload3();
      chk_order("rr_order", '{0, 1, 0, 1, 0, 1});
      SPI_ARB_RR = 1'b0;
      for (int i = 0; i < 3; i++) step();

      // Overflow of ch1 with output stalled
      SCHED_READY = 1'b0;
      for (int i = 0; i < 130; i++) begin
         PUSH_VALID = 2'b10;
         PUSH_DATA  = {12'(i), 12'h000};
         step();
      end
      PUSH_VALID = '0;
      chk("ovf_full", 32'(PUSH_FULL), 32'b10);
      chk("ovf_drop", 32'(SCHED_DROP_CNT), 32'd1);
      SPI_DROP_CLR = 1'b1;
      step();
      SPI_DROP_CLR = 1'b0;
      for (int i = 0; i < 3; i++) step();
      chk("clr_drop", 32'(SCHED_DROP_CNT), 32'd0);

      // Backpressure: hold 5 cycles, then drain
      for (int i = 0; i < 5; i++) step();
      SCHED_READY = 1'b1;
      for (int i = 0; i < 135; i++) step();
      chk("drain_empty", 32'(SCHED_EMPTY), 32'd1);

      // Open loop suppresses ch0
      SPI_OPEN_LOOP = 1'b1;
      for (int i = 0; i < 3; i++) step();
      for (int i = 0; i < 5; i++) begin
         PUSH_VALID = 2'b01;
         PUSH_DATA  = {12'h000, 12'(12'h0A0 + i)};
         step();
      end
      PUSH_VALID = '0;
      step(); step();
      chk("ol_valid", 32'(SCHED_VALID), 32'd0);
      chk("ol_drop", 32'(SCHED_DROP_CNT), 32'd0);
      chk("ol_empty", 32'(SCHED_EMPTY), 32'd1);
      SPI_OPEN_LOOP = 1'b0;
      for (int i = 0; i < 3; i++) step();

      // Randomised traffic with phases of heavy stall
      for (int cyc = 0; cyc < 3000; cyc++) begin
         int rp;
         rp = ((cyc / 400) % 2 == 0) ? 80 : 15;
         PUSH_VALID  = NCH'($urandom);
         PUSH_DATA   = (NCH*DW)'({$urandom, $urandom});
         SCHED_READY = ($urandom_range(99) < rp);
         if ($urandom_range(99) < 3) SPI_ARB_RR = ~SPI_ARB_RR;
         if ($urandom_range(199) < 2) SPI_OPEN_LOOP = ~SPI_OPEN_LOOP;
         SPI_DROP_CLR = ($urandom_range(299) == 0);
         step();
      end

      // Reset mid-stream discards everything
      SCHED_READY = 1'b0;
      PUSH_VALID  = 2'b11;
      for (int i = 0; i < 4; i++) step();
      do_reset();
      PUSH_VALID   = '0;
      SCHED_READY  = 1'b1;
      SPI_DROP_CLR = 1'b0;
      for (int i = 0; i < 4; i++) step();
      chk("post_rst_valid", 32'(SCHED_VALID), 32'd0);
      chk("post_rst_empty", 32'(SCHED_EMPTY), 32'd1);

      $display("== %0d vectors applied, %0d miscompares ==", vec, mis);
      $finish;
   end

endmodule
